// File: rtl/tm1638_spi_tx.sv
// TM1638 serial transmitter: an 18-bit word FIFO feeding a STB/SCLK/DIO serializer.
// Each word sends one or two bytes, LSB first, inside a single STB-low frame.
module tm1638_spi_tx #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned GAP_CYCLES = 8
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst,
  input  logic [17:0]            i_Data,
  input  logic                   i_Write,
  output logic                   o_Full,
  output logic                   o_Empty,
  output logic [$clog2(DEPTH):0] o_Level,
  output logic                   o_Busy,
  output logic                   o_Overflow,
  output logic                   o_STB,
  output logic                   o_SCLK,
  output logic                   o_DIO
);

  localparam int unsigned WW      = 18;
  localparam int unsigned AW      = $clog2(DEPTH);
  localparam int unsigned LW      = AW + 1;
  localparam int unsigned CNT_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam int unsigned H_LAST  = CLK_DIV - 1;
  localparam int unsigned G_LAST  = GAP_CYCLES - 1;
  localparam int unsigned BW      = 5;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    BIT_LO = 3'd2,
    BIT_HI = 3'd3,
    END    = 3'd4,
    GAP    = 3'd5
  } state_t;

  // FIFO storage and bookkeeping
  logic [WW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] count_q, count_d;
  logic          full_q, empty_q, ovf_q;
  logic          push_c, pop_c;
  logic [WW-1:0] head_c;

  // Serializer state
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   sh_q, sh_d;
  logic [BW-1:0] bits_q, bits_d;
  logic          stb_q, stb_d;
  logic          sclk_q, sclk_d;
  logic          dio_q, dio_d;
  logic          busy_q, busy_d;

  assign push_c = i_Write && !full_q;
  assign head_c = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + LW'(1);
      2'b01:   count_d = count_q - LW'(1);
      default: count_d = count_q;
    endcase
  end

  // Full/empty/level are registered from the next count so they always agree
  always_ff @(posedge i_Clk) begin
    if (!i_Rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      if (push_c) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      full_q  <= (count_d == LW'(DEPTH));
      empty_q <= (count_d == '0);
      if (i_Write && full_q) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst && push_c) mem_q[wr_ptr_q] <= i_Data;
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      bits_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      bits_q  <= bits_d;
    end
  end

  // Next state plus pin values; pins are registered, so they trail the state by one cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    bits_d  = bits_q;
    pop_c   = 1'b0;
    stb_d   = 1'b1;
    sclk_d  = 1'b1;
    dio_d   = 1'b1;
    busy_d  = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (!empty_q) begin
          pop_c   = 1'b1;
          cnt_d   = '0;
          state_d = START;
          // Two-byte words are stored so that bit 0 of [15:8] leaves first
          if (head_c[17:16] == 2'b01) begin
            sh_d   = {head_c[7:0], head_c[15:8]};
            bits_d = BW'(16);
          end else begin
            sh_d   = {8'hFF, head_c[7:0]};
            bits_d = BW'(8);
          end
        end
      end
      START: begin
        stb_d = 1'b0;
        if (cnt_q == CW'(H_LAST)) begin
          cnt_d   = '0;
          state_d = BIT_LO;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      BIT_LO: begin
        stb_d  = 1'b0;
        sclk_d = 1'b0;
        dio_d  = sh_q[0];
        if (cnt_q == CW'(H_LAST)) begin
          cnt_d   = '0;
          state_d = BIT_HI;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      BIT_HI: begin
        stb_d = 1'b0;
        dio_d = sh_q[0];
        if (cnt_q == CW'(H_LAST)) begin
          cnt_d   = '0;
          sh_d    = sh_q >> 1;
          bits_d  = bits_q - BW'(1);
          state_d = (bits_q == BW'(1)) ? END : BIT_LO;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      END: begin
        stb_d = 1'b0;
        if (cnt_q == CW'(H_LAST)) begin
          cnt_d   = '0;
          state_d = GAP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      GAP: begin
        if (cnt_q == CW'(G_LAST)) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst) begin
      stb_q  <= 1'b1;
      sclk_q <= 1'b1;
      dio_q  <= 1'b1;
      busy_q <= 1'b0;
    end else begin
      stb_q  <= stb_d;
      sclk_q <= sclk_d;
      dio_q  <= dio_d;
      busy_q <= busy_d;
    end
  end

  assign o_Full     = full_q;
  assign o_Empty    = empty_q;
  assign o_Level    = count_q;
  assign o_Busy     = busy_q;
  assign o_Overflow = ovf_q;
  assign o_STB      = stb_q;
  assign o_SCLK     = sclk_q;
  assign o_DIO      = dio_q;

endmodule

// File: tb/tb_tm1638_spi_tx.sv
// Bench for tm1638_spi_tx: directed writes, a frame-decoding monitor and a queue of expected frames.
module tb_tm1638_spi_tx;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned CLK_DIV = 2;
  localparam int unsigned GAP     = 4;
  localparam int unsigned LW      = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [17:0]   data;
  logic          wr;
  logic          full, empty, busy, ovf, stb, sclk, dio;
  logic [LW-1:0] level;

  always #5 clk = ~clk;

  tm1638_spi_tx #(.DEPTH(DEPTH), .CLK_DIV(CLK_DIV), .GAP_CYCLES(GAP)) dut (
    .i_Clk(clk), .i_Rst(rst_n), .i_Data(data), .i_Write(wr),
    .o_Full(full), .o_Empty(empty), .o_Level(level), .o_Busy(busy),
    .o_Overflow(ovf), .o_STB(stb), .o_SCLK(sclk), .o_DIO(dio)
  );

  typedef struct {
    logic [15:0] bits;
    int          nbits;
  } frame_t;

  frame_t exp_q[$];
  int total = 0;
  int bad = 0;
  int frames_seen = 0;
  int sclk_rises = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Bits in transmit order: index 0 leaves first
  function automatic frame_t mk(input logic [17:0] d);
    frame_t f;
    if (d[17:16] == 2'b01) begin
      f.bits  = {d[7:0], d[15:8]};
      f.nbits = 16;
    end else begin
      f.bits  = {8'h00, d[7:0]};
      f.nbits = 8;
    end
    return f;
  endfunction

  // Frame decoder: samples 1 time unit after each rising edge
  logic        prev_stb = 1'b1;
  logic        prev_sclk = 1'b1;
  logic [15:0] got = '0;
  int          nb = 0;
  int          low = 0;
  int          gap = 0;
  bit          gap_valid = 1'b0;

  always @(posedge clk) begin
    frame_t f;
    logic [15:0] mask;
    #1;
    if (rst_n !== 1'b1) begin
      prev_stb = 1'b1; prev_sclk = 1'b1; got = '0;
      nb = 0; low = 0; gap = 0; gap_valid = 1'b0;
    end else begin
      if (prev_sclk == 1'b0 && sclk == 1'b1) sclk_rises++;
      if (stb == 1'b0) begin
        if (prev_stb == 1'b1 && gap_valid) check("gap_high_cycles_min", 32'(gap >= int'(GAP)), 32'd1);
        low++;
        if (prev_sclk == 1'b0 && sclk == 1'b1) begin
          if (nb < 16) got[nb] = dio;
          nb++;
        end
      end else begin
        if (prev_stb == 1'b0) begin
          if (exp_q.size() == 0) begin
            check("unexpected_frame", 32'd1, 32'd0);
          end else begin
            f = exp_q.pop_front();
            mask = (f.nbits == 16) ? 16'hFFFF : 16'h00FF;
            check("frame_nbits", 32'(nb), 32'(f.nbits));
            check("frame_bits", 32'(got & mask), 32'(f.bits));
            check("frame_stb_low_cycles", 32'(low), 32'((2 + 2 * f.nbits) * int'(CLK_DIV)));
          end
          frames_seen++;
          nb = 0; low = 0; got = '0; gap = 0; gap_valid = 1'b1;
        end
        gap++;
      end
      prev_stb = stb;
      prev_sclk = sclk;
    end
  end

  // Drive on the falling edge, return 2 units after the following rising edge
  task automatic step(input logic r, input logic w, input logic [17:0] d);
    @(negedge clk);
    rst_n = r; wr = w; data = d;
    @(posedge clk);
    #2;
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n = 0;
    while (frames_seen < target && n < budget) begin
      step(1'b1, 1'b0, 18'h0);
      n++;
    end
    check("frame_wait_timeout", 32'(frames_seen >= target), 32'd1);
  endtask

  initial begin
    logic [17:0] w3 [6];
    logic [17:0] w4 [5];
    logic [17:0] w5 [4];
    int fb;
    int bc;
    int r0;

    rst_n = 1'b0; wr = 1'b0; data = '0;
    repeat (3) step(1'b0, 1'b0, 18'h0);
    check("rst_stb", 32'(stb), 32'd1);
    check("rst_sclk", 32'(sclk), 32'd1);
    check("rst_dio", 32'(dio), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_level", 32'(level), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    step(1'b1, 1'b0, 18'h0);

    // Single byte 0x44, STB falls two edges after the write
    exp_q.push_back(mk(18'h0_0044));
    step(1'b1, 1'b1, 18'h0_0044);
    check("t0_level", 32'(level), 32'd1);
    check("t0_empty", 32'(empty), 32'd0);
    check("t0_stb", 32'(stb), 32'd1);
    step(1'b1, 1'b0, 18'h0);
    check("t1_stb", 32'(stb), 32'd1);
    check("t1_level", 32'(level), 32'd0);
    step(1'b1, 1'b0, 18'h0);
    check("t2_stb", 32'(stb), 32'd0);
    check("t2_busy", 32'(busy), 32'd1);
    wait_frames(1, 200);
    bc = 0;
    while (busy === 1'b1 && bc < 20) begin
      bc++;
      step(1'b1, 1'b0, 18'h0);
    end
    check("gap_busy_cycles", 32'(bc), 32'(GAP));
    check("idle_stb", 32'(stb), 32'd1);

    // Two-byte frame C0 then F3
    exp_q.push_back(mk(18'h1_C0F3));
    step(1'b1, 1'b1, 18'h1_C0F3);
    wait_frames(2, 300);
    repeat (8) step(1'b1, 1'b0, 18'h0);

    // Six back-to-back writes: five accepted, sixth overflows
    w3 = '{18'h0_0001, 18'h1_A55A, 18'h2_0080, 18'h3_00FF, 18'h0_0033, 18'h0_0077};
    for (int i = 0; i < 6; i++) begin
      if (i < 5) exp_q.push_back(mk(w3[i]));
      step(1'b1, 1'b1, w3[i]);
      if (i == 3) check("ovr_full_before", 32'(full), 32'd0);
      if (i == 4) begin
        check("ovr_full", 32'(full), 32'd1);
        check("ovr_level", 32'(level), 32'(DEPTH));
        check("ovr_flag_before", 32'(ovf), 32'd0);
      end
      if (i == 5) begin
        check("ovr_flag", 32'(ovf), 32'd1);
        check("ovr_level_after", 32'(level), 32'(DEPTH));
      end
    end
    wait_frames(7, 1500);
    check("ovr_empty_after", 32'(empty), 32'd1);
    repeat (8) step(1'b1, 1'b0, 18'h0);

    // Write while full coinciding with a pop
    step(1'b0, 1'b0, 18'h0);
    check("rst2_ovf", 32'(ovf), 32'd0);
    step(1'b1, 1'b0, 18'h0);
    fb = frames_seen;
    w4 = '{18'h0_0011, 18'h0_0022, 18'h1_3344, 18'h0_0055, 18'h0_0066};
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(mk(w4[i]));
      step(1'b1, 1'b1, w4[i]);
    end
    check("fp_full", 32'(full), 32'd1);
    wait_frames(fb + 1, 300);
    repeat (3) step(1'b1, 1'b0, 18'h0);
    check("fp_level_before", 32'(level), 32'(DEPTH));
    check("fp_ovf_before", 32'(ovf), 32'd0);
    step(1'b1, 1'b1, 18'h0_00EE);
    check("fp_level_after", 32'(level), 32'(DEPTH - 1));
    check("fp_ovf_after", 32'(ovf), 32'd1);
    check("fp_full_after", 32'(full), 32'd0);
    wait_frames(fb + 5, 1500);
    repeat (8) step(1'b1, 1'b0, 18'h0);

    // Write and pop coincide at level 2
    fb = frames_seen;
    w5 = '{18'h0_00A1, 18'h1_B2C3, 18'h0_00D4, 18'h0_00E5};
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(mk(w5[i]));
      step(1'b1, 1'b1, w5[i]);
    end
    check("wp_level_start", 32'(level), 32'd2);
    wait_frames(fb + 1, 300);
    repeat (3) step(1'b1, 1'b0, 18'h0);
    check("wp_level_before", 32'(level), 32'd2);
    exp_q.push_back(mk(w5[3]));
    step(1'b1, 1'b1, w5[3]);
    check("wp_level_after", 32'(level), 32'd2);
    wait_frames(fb + 4, 1500);
    repeat (8) step(1'b1, 1'b0, 18'h0);

    // Reset in the middle of a two-byte frame with two words queued
    step(1'b1, 1'b1, 18'h1_1234);
    step(1'b1, 1'b1, 18'h0_0056);
    step(1'b1, 1'b1, 18'h0_0078);
    check("mr_level", 32'(level), 32'd2);
    repeat (20) step(1'b1, 1'b0, 18'h0);
    check("mr_stb_mid", 32'(stb), 32'd0);
    step(1'b0, 1'b1, 18'h0_0099);
    check("mr_stb", 32'(stb), 32'd1);
    check("mr_sclk", 32'(sclk), 32'd1);
    check("mr_dio", 32'(dio), 32'd1);
    check("mr_level_rst", 32'(level), 32'd0);
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_empty", 32'(empty), 32'd1);
    r0 = sclk_rises;
    fb = frames_seen;
    repeat (150) step(1'b1, 1'b0, 18'h0);
    check("mr_no_sclk", 32'(sclk_rises), 32'(r0));
    check("mr_no_frame", 32'(frames_seen), 32'(fb));
    check("mr_level_post", 32'(level), 32'd0);
    check("mr_stb_post", 32'(stb), 32'd1);

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
